// File: rtl/trisc_datapath_if.sv
// Sequencer/memory-side bus of the TRISC datapath: control word and memory
// read data in, memory address/data/strobes plus decode and flags out.
interface trisc_datapath_if #(
    parameter int DW = 12
);
    logic [15:0]   control;
    logic [DW-1:0] mem_rdata;
    logic [7:0]    mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic [10:0]   op;
    logic          zero;
    logic          carry;

    modport master (
        output control,
        output mem_rdata,
        input  mem_addr,
        input  mem_wdata,
        input  mem_re,
        input  mem_we,
        input  op,
        input  zero,
        input  carry
    );

    modport slave (
        input  control,
        input  mem_rdata,
        output mem_addr,
        output mem_wdata,
        output mem_re,
        output mem_we,
        output op,
        output zero,
        output carry
    );
endinterface

// File: rtl/trisc_datapath.sv
// TRISC accumulator datapath: PC, MAR, MDR, IR, ACC, B and carry flag,
// steered by a 16-bit control word; opcode one-hot decode fed back.
module trisc_datapath #(
    parameter int DW = 12
) (
    input  logic              CLK,
    input  logic              CLR,
    trisc_datapath_if.slave   bus
);

    // Opcode k in 1..11 maps to bit (11-k); everything else decodes to none.
    function automatic logic [10:0] decode_op(input logic [3:0] opc);
        logic [10:0] r;
        case (opc)
            4'd1:    r = 11'b100_0000_0000;
            4'd2:    r = 11'b010_0000_0000;
            4'd3:    r = 11'b001_0000_0000;
            4'd4:    r = 11'b000_1000_0000;
            4'd5:    r = 11'b000_0100_0000;
            4'd6:    r = 11'b000_0010_0000;
            4'd7:    r = 11'b000_0001_0000;
            4'd8:    r = 11'b000_0000_1000;
            4'd9:    r = 11'b000_0000_0100;
            4'd10:   r = 11'b000_0000_0010;
            4'd11:   r = 11'b000_0000_0001;
            default: r = 11'b000_0000_0000;
        endcase
        return r;
    endfunction

    logic [15:0]   ctrl_s;
    logic          mem_re_s;
    logic          mem_we_s;
    logic          mar_lock_s;
    logic [DW:0]   sum_s;
    logic [DW-1:0] inc_s;
    logic          acc_ones_s;
    logic          unused_ctrl_s;

    logic [7:0]    pc_q,  pc_d;
    logic [7:0]    mar_q, mar_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic [DW-1:0] ir_q,  ir_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] b_q,   b_d;
    logic          cy_q,  cy_d;

    assign ctrl_s        = bus.control;
    assign unused_ctrl_s = ^{ctrl_s[15], ctrl_s[13], ctrl_s[12]};

    // A write request overrides a simultaneous read; MAR freezes during any access.
    assign mem_we_s   = ctrl_s[5];
    assign mem_re_s   = ctrl_s[4] & ~ctrl_s[5];
    assign mar_lock_s = ctrl_s[4] | ctrl_s[5];

    assign sum_s      = {1'b0, acc_q} + {1'b0, b_q};
    assign inc_s      = acc_q + {{(DW-1){1'b0}}, 1'b1};
    assign acc_ones_s = &acc_q;

    // Next-state selection for every register from pre-edge values.
    always_comb begin
        pc_d  = pc_q;
        mar_d = mar_q;
        mdr_d = mdr_q;
        ir_d  = ir_q;
        acc_d = acc_q;
        b_d   = b_q;
        cy_d  = cy_q;

        if (ctrl_s[0]) begin
            pc_d = 8'h00;
        end else if (ctrl_s[1]) begin
            pc_d = ir_q[7:0];
        end else if (ctrl_s[2]) begin
            pc_d = pc_q + 8'h01;
        end else begin
            pc_d = pc_q;
        end

        if (mar_lock_s) begin
            mar_d = mar_q;
        end else if (ctrl_s[3]) begin
            mar_d = pc_q;
        end else if (ctrl_s[6]) begin
            mar_d = ir_q[7:0];
        end else begin
            mar_d = mar_q;
        end

        if (mem_re_s) begin
            mdr_d = bus.mem_rdata;
        end else begin
            mdr_d = mdr_q;
        end

        if (ctrl_s[7]) begin
            ir_d = mdr_q;
        end else begin
            ir_d = ir_q;
        end

        // CY only moves on clear, add and increment; a plain load keeps it.
        if (ctrl_s[8]) begin
            acc_d = {DW{1'b0}};
            cy_d  = 1'b0;
        end else if (ctrl_s[10]) begin
            acc_d = sum_s[DW-1:0];
            cy_d  = sum_s[DW];
        end else if (ctrl_s[9]) begin
            acc_d = inc_s;
            cy_d  = acc_ones_s;
        end else if (ctrl_s[11]) begin
            acc_d = mdr_q;
            cy_d  = cy_q;
        end else begin
            acc_d = acc_q;
            cy_d  = cy_q;
        end

        if (ctrl_s[14]) begin
            b_d = mdr_q;
        end else begin
            b_d = b_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            pc_q  <= 8'h00;
            mar_q <= 8'h00;
            mdr_q <= {DW{1'b0}};
            ir_q  <= {DW{1'b0}};
            acc_q <= {DW{1'b0}};
            b_q   <= {DW{1'b0}};
            cy_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
            b_q   <= b_d;
            cy_q  <= cy_d;
        end
    end

    assign bus.mem_addr  = mar_q;
    assign bus.mem_wdata = acc_q;
    assign bus.mem_re    = mem_re_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.op        = decode_op(ir_q[DW-1:DW-4]);
    assign bus.zero      = (acc_q == {DW{1'b0}});
    assign bus.carry     = cy_q;

endmodule

// File: tb/tb_trisc_datapath.sv
// Directed self-checking bench for trisc_datapath: fetch, add, store conflict,
// jump, increment/clear and asynchronous mid-instruction reset.
module tb_trisc_datapath;

    localparam logic [15:0] C0  = 16'h0001;
    localparam logic [15:0] C1  = 16'h0002;
    localparam logic [15:0] C2  = 16'h0004;
    localparam logic [15:0] C3  = 16'h0008;
    localparam logic [15:0] C4  = 16'h0010;
    localparam logic [15:0] C5  = 16'h0020;
    localparam logic [15:0] C6  = 16'h0040;
    localparam logic [15:0] C7  = 16'h0080;
    localparam logic [15:0] C8  = 16'h0100;
    localparam logic [15:0] C9  = 16'h0200;
    localparam logic [15:0] C10 = 16'h0400;
    localparam logic [15:0] C11 = 16'h0800;
    localparam logic [15:0] C14 = 16'h4000;
    localparam logic [15:0] RSV = 16'hB000;

    logic clk;
    logic clr;
    int   total;
    int   bad;

    trisc_datapath_if #(.DW(12)) bus ();

    trisc_datapath #(.DW(12)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [15:0] c, input logic [11:0] d);
        @(negedge clk);
        bus.control   = c;
        bus.mem_rdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [11:0] v);
        step(C4, v);
        step(C7, 12'h000);
    endtask

    task automatic load_acc(input logic [11:0] v);
        step(C4, v);
        step(C11, 12'h000);
    endtask

    task automatic test_reset;
        #1;
        total++; if (bus.mem_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h exp=00", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 12'h000) begin bad++; $display("FAIL rst_wdata got=%h exp=000", bus.mem_wdata); end
        total++; if (bus.op !== 11'b0) begin bad++; $display("FAIL rst_op got=%b exp=0", bus.op); end
        total++; if ({bus.zero, bus.carry} !== 2'b10) begin bad++; $display("FAIL rst_flags got=%b exp=10", {bus.zero, bus.carry}); end
        total++; if ({bus.mem_re, bus.mem_we} !== 2'b00) begin bad++; $display("FAIL rst_strobes_idle got=%b exp=00", {bus.mem_re, bus.mem_we}); end
        bus.control = C4;
        #1;
        total++; if ({bus.mem_re, bus.mem_we} !== 2'b10) begin bad++; $display("FAIL rst_strobes_c4 got=%b exp=10", {bus.mem_re, bus.mem_we}); end
        @(negedge clk);
        bus.control = 16'h0000;
        clr = 1'b1;
        @(posedge clk);
        #1;
        total++; if (dut.pc_q !== 8'h00 || dut.mdr_q !== 12'h000) begin bad++; $display("FAIL rst_idle_edge pc=%h mdr=%h exp=00/000", dut.pc_q, dut.mdr_q); end
    endtask

    task automatic test_fetch;
        load_ir(12'h005);
        step(C1, 12'h000);
        step(C3, 12'h000);
        step(C4, 12'h3A0);
        step(C4, 12'h3A0);
        total++; if (bus.op !== 11'b0) begin bad++; $display("FAIL fetch_op_before got=%b exp=0", bus.op); end
        step(C2 | C7, 12'h000);
        total++; if (bus.mem_addr !== 8'h05) begin bad++; $display("FAIL fetch_mar got=%h exp=05", bus.mem_addr); end
        total++; if (dut.mdr_q !== 12'h3A0) begin bad++; $display("FAIL fetch_mdr got=%h exp=3a0", dut.mdr_q); end
        total++; if (dut.ir_q !== 12'h3A0) begin bad++; $display("FAIL fetch_ir got=%h exp=3a0", dut.ir_q); end
        total++; if (dut.pc_q !== 8'h06) begin bad++; $display("FAIL fetch_pc got=%h exp=06", dut.pc_q); end
        total++; if (bus.op !== 11'b00100000000) begin bad++; $display("FAIL fetch_op got=%b exp=00100000000", bus.op); end
    endtask

    task automatic test_add;
        load_acc(12'hFFF);
        step(C4, 12'h002);
        step(C14, 12'h000);
        step(C10 | C11, 12'h000);
        total++; if (bus.mem_wdata !== 12'h001) begin bad++; $display("FAIL add_acc got=%h exp=001", bus.mem_wdata); end
        total++; if ({bus.carry, bus.zero} !== 2'b10) begin bad++; $display("FAIL add_flags got=%b exp=10", {bus.carry, bus.zero}); end
        step(C4, 12'h000);
        step(C14, 12'h000);
        total++; if (bus.carry !== 1'b1) begin bad++; $display("FAIL load_b_keeps_cy got=%b exp=1", bus.carry); end
        step(C9, 12'h000);
        total++; if (bus.mem_wdata !== 12'h002 || bus.carry !== 1'b0) begin bad++; $display("FAIL inc_clears_cy acc=%h cy=%b exp=002/0", bus.mem_wdata, bus.carry); end
    endtask

    task automatic test_store_conflict;
        load_acc(12'h5A5);
        load_ir(12'h020);
        step(C6, 12'h000);
        @(negedge clk);
        bus.control   = C4 | C5;
        bus.mem_rdata = 12'hFFF;
        #1;
        total++; if ({bus.mem_we, bus.mem_re} !== 2'b10) begin bad++; $display("FAIL st_strobes got=%b exp=10", {bus.mem_we, bus.mem_re}); end
        total++; if (bus.mem_addr !== 8'h20 || bus.mem_wdata !== 12'h5A5) begin bad++; $display("FAIL st_bus addr=%h data=%h exp=20/5a5", bus.mem_addr, bus.mem_wdata); end
        @(posedge clk);
        #1;
        total++; if (dut.mdr_q !== 12'h020) begin bad++; $display("FAIL st_mdr_hold got=%h exp=020", dut.mdr_q); end
        step(C3 | C4, 12'h111);
        total++; if (bus.mem_addr !== 8'h20 || dut.mdr_q !== 12'h111) begin bad++; $display("FAIL mar_lock addr=%h mdr=%h exp=20/111", bus.mem_addr, dut.mdr_q); end
    endtask

    task automatic test_jump;
        load_ir(12'h010);
        step(C1, 12'h000);
        load_ir(12'h87F);
        total++; if (bus.op !== 11'b00000001000) begin bad++; $display("FAIL jmp_op got=%b exp=00000001000", bus.op); end
        step(C1 | C3, 12'h000);
        total++; if (bus.mem_addr !== 8'h10 || dut.pc_q !== 8'h7F) begin bad++; $display("FAIL jmp_pc_mar mar=%h pc=%h exp=10/7f", bus.mem_addr, dut.pc_q); end
        step(RSV, 12'h000);
        step(16'h0000, 12'h000);
        total++; if (dut.pc_q !== 8'h7F || dut.ir_q !== 12'h87F || bus.mem_addr !== 8'h10) begin bad++; $display("FAIL jmp_idle pc=%h ir=%h mar=%h exp=7f/87f/10", dut.pc_q, dut.ir_q, bus.mem_addr); end
        load_ir(12'h0FF);
        step(C1, 12'h000);
        step(C2, 12'h000);
        total++; if (dut.pc_q !== 8'h00) begin bad++; $display("FAIL pc_wrap got=%h exp=00", dut.pc_q); end
        step(C0 | C2, 12'h000);
        total++; if (dut.pc_q !== 8'h00) begin bad++; $display("FAIL pc_c0_prio got=%h exp=00", dut.pc_q); end
    endtask

    task automatic test_inc_clr;
        load_acc(12'hFFF);
        step(C9, 12'h000);
        total++; if (bus.mem_wdata !== 12'h000 || {bus.carry, bus.zero} !== 2'b11) begin bad++; $display("FAIL inc_wrap acc=%h cz=%b exp=000/11", bus.mem_wdata, {bus.carry, bus.zero}); end
        step(C8, 12'h000);
        total++; if (bus.carry !== 1'b0) begin bad++; $display("FAIL clr_cy got=%b exp=0", bus.carry); end
        step(C9, 12'h000);
        step(C8 | C9, 12'h000);
        total++; if (bus.mem_wdata !== 12'h000) begin bad++; $display("FAIL clr_prio got=%h exp=000", bus.mem_wdata); end
    endtask

    task automatic test_mid_reset;
        load_acc(12'h123);
        step(C4, 12'h456);
        step(C14, 12'h000);
        load_ir(12'hB42);
        total++; if (bus.op !== 11'b00000000001) begin bad++; $display("FAIL op_11 got=%b exp=00000000001", bus.op); end
        step(C3 | C2, 12'h000);
        @(negedge clk);
        bus.control = C10;
        #2;
        clr = 1'b0;
        #1;
        total++; if (dut.pc_q !== 8'h00 || dut.mar_q !== 8'h00 || dut.mdr_q !== 12'h000 || dut.ir_q !== 12'h000) begin bad++; $display("FAIL mrst_regs pc=%h mar=%h mdr=%h ir=%h exp=0", dut.pc_q, dut.mar_q, dut.mdr_q, dut.ir_q); end
        total++; if (dut.acc_q !== 12'h000 || dut.b_q !== 12'h000 || dut.cy_q !== 1'b0 || bus.zero !== 1'b1) begin bad++; $display("FAIL mrst_alu acc=%h b=%h cy=%b z=%b exp=0/0/0/1", dut.acc_q, dut.b_q, dut.cy_q, bus.zero); end
        @(negedge clk);
        bus.control = 16'h0000;
        clr = 1'b1;
        @(posedge clk);
        #1;
        total++; if (dut.pc_q !== 8'h00 || dut.acc_q !== 12'h000 || dut.b_q !== 12'h000) begin bad++; $display("FAIL mrst_release pc=%h acc=%h b=%h exp=0", dut.pc_q, dut.acc_q, dut.b_q); end
        load_ir(12'hC34);
        total++; if (bus.op !== 11'b0) begin bad++; $display("FAIL op_12 got=%b exp=0", bus.op); end
        load_ir(12'h1FF);
        total++; if (bus.op !== 11'b10000000000) begin bad++; $display("FAIL op_1 got=%b exp=10000000000", bus.op); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        clr           = 1'b0;
        bus.control   = 16'h0000;
        bus.mem_rdata = 12'h000;
        test_reset();
        test_fetch();
        test_add();
        test_store_conflict();
        test_jump();
        test_inc_clr();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trisc_datapath.md
TRISC_DATAPATH -- requirements
Module: trisc_datapath

Interface
REQ-001 The block SHALL have the parameter DW, default 12, meaning data/instruction word width; IR[DW-1:DW-4] is the opcode and IR[7:0] is the operand address.
REQ-002 The block SHALL have the port CLK  input  1  clock; all registers update on the rising edge.
REQ-003 The block SHALL have the port CLR  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have the port control  input  16  one-hot-or-combined control word from the sequencer, which changes on falling edges.
REQ-005 The block SHALL have the port mem_rdata  input  DW  memory read data, valid in the same cycle as mem_re.
REQ-006 The block SHALL have the port mem_addr  output  8  equal to MAR.
REQ-007 The block SHALL have the port mem_wdata  output  DW  equal to ACC.
REQ-008 The block SHALL have the ports mem_re  output  1  and mem_we  output  1, the memory read and write strobes.
REQ-009 The block SHALL have the port op  output  11  one-hot decode of the IR opcode, fed back to the sequencer.
REQ-010 The block SHALL have the ports zero  output  1  (ACC==0) and carry  output  1  (carry flag).

Function
REQ-011 Internal registers SHALL be PC[7:0], MAR[7:0], MDR[DW-1:0], IR[DW-1:0], ACC[DW-1:0], B[DW-1:0], and CY.
REQ-012 Control bits SHALL have these meanings:
- C0: PC<=0
- C1: PC<=IR[7:0]
- C2: PC<=PC+1
- C3: MAR<=PC
- C4: memory read, MDR<=mem_rdata
- C5: memory write of ACC
- C6: MAR<=IR[7:0]
- C7: IR<=MDR
- C8: ACC<=0, CY<=0
- C9: ACC<=ACC+1
- C10: ACC<=ACC+B
- C11: ACC<=MDR
- C14: B<=MDR
- C12, C13, C15: reserved, no effect
REQ-013 PC priority SHALL be C0 > C1 > C2; PC increments wrap from 8'hFF to 8'h00.
REQ-014 MAR priority SHALL be C3 > C6.
REQ-015 ACC priority SHALL be C8 > C10 > C9 > C11, so C10+C11 together performs the add.
REQ-016 All register transfers SHALL sample pre-edge values, so C1+C3 loads the old PC into MAR while PC takes IR[7:0].
REQ-017 The C10 add SHALL be DW-bit with CY<=carry-out.
REQ-018 C9 SHALL set CY<=1 only when ACC wraps from all-ones to 0, and SHALL otherwise clear CY.
REQ-019 C11 and C14 SHALL leave CY unchanged.
REQ-020 mem_we SHALL equal C5, combinationally.
REQ-021 mem_re SHALL equal C4 AND NOT C5; when C4 and C5 are both set, the write wins and MDR holds.
REQ-022 MDR SHALL load only when mem_re=1.
REQ-023 MAR SHALL be stable for every cycle in which C4 or C5 is set, so multi-cycle memory accesses see a constant address.
REQ-024 Opcode decode SHALL be combinational from IR:
- opcode k in 1..11 gives op = 1 << (11-k); e.g. LDA=1 gives bit10, STA=2 gives bit9, ADD=3 gives bit8, INC=6 gives bit5, CLR=7 gives bit4, JMP=8 gives bit3
- opcode 0 and 12..15 give op = 0
REQ-025 op SHALL change only after the rising edge that loads IR.
REQ-026 A control word of 0 SHALL leave all state unchanged.

Reset
REQ-027 CLR=0 SHALL immediately clear PC, MAR, MDR, IR, ACC, B and CY, independent of CLK.
REQ-028 During CLR=0 the outputs SHALL be: mem_addr=0, mem_wdata=0, op=0, zero=1, carry=0; mem_re and mem_we SHALL follow control per REQ-020 and REQ-021.
REQ-029 CLR asserted in the middle of an instruction SHALL abort it; registers SHALL hold zero until the first rising edge after CLR returns to 1.

Verification
REQ-030 The bench SHALL cover fetch: PC=8'h05, control C3, then C4 for 2 cycles with mem_rdata=12'h3A0, then C2+C7 -> MAR=05, MDR=3A0, IR=3A0, PC=06, op=11'b00100000000.
REQ-031 The bench SHALL cover ADD with carry: ACC=FFF, MDR=002, control C14, then C10+C11 -> ACC=001, CY=1, zero=0.
REQ-032 The bench SHALL cover store conflict: MAR=20, ACC=5A5, control C4+C5 -> mem_we=1, mem_re=0, mem_addr=20, mem_wdata=5A5, MDR unchanged.
REQ-033 The bench SHALL cover jump: PC=10, IR=8'h8_7F (opcode 8), control C1+C3 -> MAR=10, PC=7F; PC=FF with C2 -> PC=00.
REQ-034 The bench SHALL cover INC wrap and CLR: ACC=FFF, control C9 -> ACC=000, CY=1, zero=1; then C8 -> CY=0; then C8+C9 -> ACC=000.
REQ-035 The bench SHALL cover mid-operation reset: assert CLR=0 between edges during C10 -> all registers 0 immediately; the first edge after release with control=0 leaves them at 0; opcode 12 in IR gives op=0.
